xnor_serial_compare: RTL and testbench
======================================

XNOR_SERIAL_COMPARE -- requirements
Module: xnor_serial_compare

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request to compare; sampled only in IDLE.
REQ-005 a_in  input  WIDTH  operand A; captured on accepted start.
REQ-006 b_in  input  WIDTH  operand B; captured on accepted start.
REQ-007 gate_a  output  1  bit driven to input a of the shared external switch-level XNOR cell.
REQ-008 gate_b  output  1  bit driven to input b of the shared external XNOR cell.
REQ-009 gate_y  input  1  XNOR cell output; combinational return of gate_a/gate_b.
REQ-010 busy  output  1  high while a comparison is in progress.
REQ-011 done  output  1  one-cycle pulse when result is valid.
REQ-012 equal  output  1  1 when captured A equals captured B; held until next accepted start.
REQ-013 match_cnt  output  $clog2(WIDTH+1)  count of bit positions where A and B agree; present only with MATCH_COUNT_EN.

Function
REQ-014 FSM states IDLE, SHIFT, DONE; encoding free.
REQ-015 IDLE: start=1 -> capture a_in/b_in into shift registers, clear bit index and accumulators, go SHIFT; start=0 -> stay.
REQ-016 SHIFT: gate_a/gate_b = LSB of respective shift registers; gate_y sampled same cycle; shift registers shift right by 1 each cycle.
REQ-017 Equality accumulator initialises to 1 on capture and is ANDed with gate_y each SHIFT cycle.
REQ-018 SHIFT lasts exactly WIDTH cycles (bit index 0..WIDTH-1), LSB first, then go DONE.
REQ-019 DONE: done=1 for one cycle, equal updated from accumulator, go IDLE unconditionally.
REQ-020 Latency: start accepted on edge N -> done high in cycle N+WIDTH+1; a back-to-back start in the cycle after done is accepted.
REQ-021 busy=1 in SHIFT and DONE, 0 in IDLE.
REQ-022 start while busy is ignored; captured operands are not disturbed by a_in/b_in changes after capture.
REQ-023 gate_a=0 and gate_b=0 in IDLE and DONE.
REQ-024 equal changes only on the DONE-cycle edge; it retains its value through IDLE and the next SHIFT phase until updated.
REQ-025 gate_y is treated as 0 if X/Z is sampled; this is a mismatch, not a hold.

Reset
REQ-026 rst_n low forces IDLE immediately, regardless of clock.
REQ-027 Reset values: busy=0, done=0, equal=0, gate_a=0, gate_b=0, match_cnt=0, shift registers and bit index 0.
REQ-028 Reset mid-SHIFT abandons the comparison; no done pulse is produced for it.
REQ-029 After rst_n deasserts, the first start is accepted on the first rising edge at which start=1.

Configuration
REQ-030 Macro MATCH_COUNT_EN: when defined, a match counter increments on each SHIFT cycle with gate_y=1, clears on capture, and is latched to match_cnt in DONE alongside equal.
REQ-031 Without MATCH_COUNT_EN, the match_cnt port and counter logic are absent; all other behaviour is identical.

Verification
REQ-032 WIDTH=8, A=8'hA5, B=8'hA5, start pulse -> busy for 9 cycles, done at start+9, equal=1, match_cnt=8.
REQ-033 A=8'hA5, B=8'hA4 -> equal=0, match_cnt=7; gate_a/gate_b sequence LSB first: 1/0, 0/0, 1/1, ...
REQ-034 A=8'h00, B=8'hFF -> equal=0, match_cnt=0; then start held high continuously -> new capture in cycle after done, second done 10 cycles after first.
REQ-035 start pulsed at SHIFT cycle 3 with different a_in -> ignored; result reflects original operands.
REQ-036 rst_n low at SHIFT cycle 4 -> all outputs at reset values asynchronously, no done pulse; next start completes normally with equal correct.
REQ-037 Build without MATCH_COUNT_EN -> REQ-032 and REQ-033 pass on equal/done/busy timing.

Source files
------------

// File: rtl/xnor_serial_compare.sv
// xnor_serial_compare
//
// Compares two WIDTH-bit operands one bit per cycle, LSB first, using a
// shared external XNOR cell. Each SHIFT cycle the LSBs of the captured
// operands are presented on gate_a/gate_b and the cell's answer on gate_y is
// folded into an equality accumulator (and optionally a match counter).
//
// Optional feature macro: MATCH_COUNT_EN adds the match_cnt output, which
// reports how many bit positions of A and B agree.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   compare request, sampled only while idle
//   a_in       in   [WIDTH] operand A, captured on accepted start
//   b_in       in   [WIDTH] operand B, captured on accepted start
//   gate_a     out  bit driven to XNOR cell input a
//   gate_b     out  bit driven to XNOR cell input b
//   gate_y     in   XNOR cell output (combinational return)
//   busy       out  high in SHIFT and DONE
//   done       out  one-cycle pulse, result valid
//   equal      out  A == B, held until the next result
//   match_cnt  out  [$clog2(WIDTH+1)] agreeing bit count (MATCH_COUNT_EN only)
//
// State  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; gates driven low
// S_SHIFT| one operand bit per cycle through the XNOR cell (WIDTH cycles)
// S_DONE | done pulse; result registers already hold the new result

module xnor_serial_compare #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             gate_a,
  output logic             gate_b,
  input  logic             gate_y,
  output logic             busy,
  output logic             done,
  output logic             equal
`ifdef MATCH_COUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] match_cnt
`endif
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [IW-1:0]    r_idx;
  logic             r_acc;
  logic             r_equal;

  logic w_capture;
  logic w_shift;
  logic w_last;
  logic w_y;
  logic w_busy;
  logic w_done;
  logic w_gate_a;
  logic w_gate_b;

  assign w_last = (r_idx == IW'(WIDTH - 1));

  // An unknown cell output counts as a mismatch: only a clean 1 is a match.
  always_comb begin
    w_y = 1'b0;
    if (gate_y == 1'b1) w_y = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_shift     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_gate_a    = 1'b0;
    w_gate_b    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_capture   = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_busy   = 1'b1;
        w_shift  = 1'b1;
        w_gate_a = r_sa[0];
        w_gate_b = r_sb[0];
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Results are latched on the edge that enters DONE, folding in the final
  // bit, so equal is already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_idx   <= '0;
      r_acc   <= 1'b0;
      r_equal <= 1'b0;
    end else if (w_capture) begin
      r_sa  <= a_in;
      r_sb  <= b_in;
      r_idx <= '0;
      r_acc <= 1'b1;
    end else if (w_shift) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_acc <= r_acc & w_y;
      if (w_last) begin
        r_idx   <= '0;
        r_equal <= r_acc & w_y;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

`ifdef MATCH_COUNT_EN
  logic [CW-1:0] r_mcnt;
  logic [CW-1:0] r_match_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcnt      <= '0;
      r_match_cnt <= '0;
    end else if (w_capture) begin
      r_mcnt <= '0;
    end else if (w_shift) begin
      r_mcnt <= r_mcnt + CW'(w_y);
      if (w_last) r_match_cnt <= r_mcnt + CW'(w_y);
    end
  end

  assign match_cnt = r_match_cnt;
`endif

  assign gate_a = w_gate_a;
  assign gate_b = w_gate_b;
  assign busy   = w_busy;
  assign done   = w_done;
  assign equal  = r_equal;

endmodule

// File: tb/tb_xnor_serial_compare.sv
// Self-checking bench for xnor_serial_compare (WIDTH=8). The XNOR cell is
// modelled here; expected results come from whole-word arithmetic on the
// operands (A == B, count of agreeing bits) and fixed cycle latencies.
// match_cnt checks are active when MATCH_COUNT_EN is defined.

module tb_xnor_serial_compare;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         gate_a;
  logic         gate_b;
  logic         gate_y;
  logic         busy;
  logic         done;
  logic         equal;
`ifdef MATCH_COUNT_EN
  logic [CW-1:0] match_cnt;
`endif

  int   n_pass  = 0;
  int   n_total = 0;
  logic exp_equal = 1'b0;
  int   exp_match = 0;

  always #5 clk = ~clk;

  // Shared external XNOR cell.
  assign gate_y = ~(gate_a ^ gate_b);

  xnor_serial_compare #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .gate_a (gate_a),
    .gate_b (gate_b),
    .gate_y (gate_y),
    .busy   (busy),
    .done   (done),
    .equal  (equal)
`ifdef MATCH_COUNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset_outputs(input string where);
    chk({where, "_busy"},   32'(busy),   32'd0);
    chk({where, "_done"},   32'(done),   32'd0);
    chk({where, "_equal"},  32'(equal),  32'd0);
    chk({where, "_gate_a"}, 32'(gate_a), 32'd0);
    chk({where, "_gate_b"}, 32'(gate_b), 32'd0);
`ifdef MATCH_COUNT_EN
    chk({where, "_match"},  32'(match_cnt), 32'd0);
`endif
  endtask

  task automatic chk_result(input string where);
    chk({where, "_equal"}, 32'(equal), 32'(exp_equal));
`ifdef MATCH_COUNT_EN
    chk({where, "_match"}, 32'(match_cnt), 32'(exp_match));
`endif
  endtask

  // One comparison with strict cycle checking. inj_at >= 0 pulses start with
  // a different a_in at that SHIFT cycle; abort_at >= 0 resets at that cycle.
  task automatic compare(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inj_at, input int abort_at);
    logic ref_eq;
    int   ref_m;
    logic [W-1:0] agree;
    ref_eq = (a == b);
    agree  = ~(a ^ b);
    ref_m  = $countones(agree);

    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(negedge clk);
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    for (int k = 0; k < W; k++) begin
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        repeat (3) begin
          @(negedge clk);
          chk("abort_hold_done", 32'(done), 32'd0);
          chk("abort_hold_busy", 32'(busy), 32'd0);
        end
        rst_n     = 1'b1;
        exp_equal = 1'b0;
        exp_match = 0;
        return;
      end
      chk("shift_busy",   32'(busy),   32'd1);
      chk("shift_done",   32'(done),   32'd0);
      chk("shift_gate_a", 32'(gate_a), 32'(a[k]));
      chk("shift_gate_b", 32'(gate_b), 32'(b[k]));
      chk_result("shift_held");
      if (k == inj_at) begin
        start = 1'b1;
        a_in  = ~a;
      end
      @(negedge clk);
      start = 1'b0;
    end
    exp_equal = ref_eq;
    exp_match = ref_m;
    chk("done_pulse",  32'(done),   32'd1);
    chk("done_busy",   32'(busy),   32'd1);
    chk("done_gate_a", 32'(gate_a), 32'd0);
    chk("done_gate_b", 32'(gate_b), 32'd0);
    chk_result("done");
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk_result("idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [W-1:0] x, y;

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("post_reset");

    compare(8'hA5, 8'hA5, -1, -1);
    compare(8'hA5, 8'hA4, -1, -1);

    // Start held high: second capture in the idle cycle after done.
    @(negedge clk);
    start = 1'b1;
    a_in  = 8'h00;
    b_in  = 8'hFF;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < 40);
    chk("b2b_first_latency", 32'(c), 32'(W + 1));
    exp_equal = 1'b0;
    exp_match = 0;
    chk_result("b2b_first");
    x = W'($urandom);
    y = ($urandom_range(0, 1) == 1) ? x : W'($urandom);
    a_in = x;
    b_in = y;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < 40);
    start = 1'b0;
    chk("b2b_gap", 32'(c), 32'(W + 2));
    begin
      logic [W-1:0] ag;
      ag = ~(x ^ y);
      exp_equal = (x == y);
      exp_match = $countones(ag);
    end
    chk_result("b2b_second");
    @(negedge clk);
    chk("b2b_idle_busy", 32'(busy), 32'd0);

    // start while busy is ignored.
    x = W'($urandom);
    compare(x, x, 3, -1);

    // Reset mid-SHIFT after an equal=1 result, then a normal compare.
    compare(8'h3C, 8'h3C, -1, -1);
    compare(8'h12, 8'h34, -1, 4);
    compare(8'h81, 8'h81, -1, -1);

    for (int i = 0; i < 6; i++) begin
      x = W'($urandom);
      y = ($urandom_range(0, 1) == 1) ? x : W'($urandom);
      compare(x, y, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
